// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and BCD constant helper for score_bcd_accum
package score_pkg;

    typedef enum logic [1:0] {
        GR_MISS    = 2'b00,
        GR_GOOD    = 2'b01,
        GR_PERFECT = 2'b10
    } grade_t;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        S_IDLE,
        S_ADD
    } state_t;

    // Converts a non-negative point constant into packed BCD, digit 0 in the LSBs (up to 16 digits)
    function automatic logic [63:0] pts_to_bcd(input int pts);
        logic [63:0] bcd;
        int          v;
        bcd = '0;
        v   = pts;
        for (int i = 0; i < 16; i++) begin
            bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD adder with +6 correction
module bcd_digit_add
    import score_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] raw;

    // Binary add, then skip the six unused codes when the digit exceeds 9
    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw > 5'd9) begin
            sum  = 4'(raw + 5'd6);
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/score_bcd_accum.sv
// rtl/score_bcd_accum.sv - N-lane hit scorer with saturating digit-serial BCD score; hiscore under SCORE_HISCORE_EN
module score_bcd_accum #(
    parameter int LANES       = 5,
    parameter int DIGITS      = 6,
    parameter int PERFECT_PTS = 100,
    parameter int GOOD_PTS    = 50,
    parameter int COMBO_W     = 10,
    parameter int COMBO_STEP  = 10,
    parameter int MAX_MULT    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [LANES-1:0]     hit_valid,
    input  logic [2*LANES-1:0]   hit_grade,
    output logic [4*DIGITS-1:0]  score_bcd,
    output logic [4*DIGITS-1:0]  hiscore_bcd,
    output logic [COMBO_W-1:0]   combo,
    output logic [2:0]           mult,
    output logic                 busy,
    output logic                 overflow,
    output logic                 dropped
);
    import score_pkg::*;

    localparam int W  = 4 * DIGITS;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [63:0]        PERFECT_FULL = pts_to_bcd(PERFECT_PTS);
    localparam logic [63:0]        GOOD_FULL    = pts_to_bcd(GOOD_PTS);
    localparam logic [W-1:0]       PERFECT_BCD  = PERFECT_FULL[W-1:0];
    localparam logic [W-1:0]       GOOD_BCD     = GOOD_FULL[W-1:0];
    localparam logic [W-1:0]       ALL_NINES    = {DIGITS{4'h9}};
    localparam logic [DW-1:0]      LAST_DIGIT   = DW'(DIGITS - 1);
    localparam logic [COMBO_W-1:0] COMBO_MAX    = {COMBO_W{1'b1}};

    state_t             state_q, state_d;
    logic [LANES-1:0]   pend_q, pend_d;
    logic [2*LANES-1:0] grade_q, grade_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [2:0]         mult_q, mult_d;
    logic [W-1:0]       addend_q, addend_d;
    logic [2:0]         rep_q, rep_d;
    logic [DW-1:0]      d_q, d_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       work_q, work_d;
    logic [W-1:0]       score_q, score_d;
    logic               ovf_q, ovf_d;
    logic               drop_q, drop_d;

    logic [LW-1:0]      sel_lane;
    logic [LANES-1:0]   consume;
    logic [1:0]         sel_grade;
    logic [COMBO_W-1:0] combo_inc;
    logic [2:0]         mult_new;
    bcd_digit_t         add_a, add_b, add_sum;
    logic               add_cout;

    // Pick the lowest-index pending lane; it is consumed only while idle and not clearing
    always_comb begin
        sel_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pend_q[i]) sel_lane = LW'(i);
        end
        consume = '0;
        if (state_q == S_IDLE && (|pend_q) && !clear) consume[sel_lane] = 1'b1;
        sel_grade = grade_q[2*sel_lane +: 2];
    end

    // Saturating combo increment and the multiplier it implies
    always_comb begin
        int unsigned m;
        combo_inc = (combo_q == COMBO_MAX) ? combo_q : combo_q + 1'b1;
        m = 1 + int'(combo_inc) / COMBO_STEP;
        if (m > MAX_MULT) m = MAX_MULT;
        mult_new = 3'(m);
    end

    // The single digit adder is time-shared across digit positions by d_q
    assign add_a = work_q[4*d_q +: 4];
    assign add_b = addend_q[4*d_q +: 4];

    bcd_digit_add u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state: clear override, FSM sequencing and pending-mask capture
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q & ~consume;
        grade_d  = grade_q;
        combo_d  = combo_q;
        mult_d   = mult_q;
        addend_d = addend_q;
        rep_d    = rep_q;
        d_d      = d_q;
        carry_d  = carry_q;
        work_d   = work_q;
        score_d  = score_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (clear) begin
            state_d = S_IDLE;
            pend_d  = '0;
            combo_d = '0;
            mult_d  = 3'd1;
            rep_d   = '0;
            d_d     = '0;
            carry_d = 1'b0;
            work_d  = '0;
            score_d = '0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|pend_q) begin
                        if (sel_grade == GR_GOOD || sel_grade == GR_PERFECT) begin
                            combo_d  = combo_inc;
                            mult_d   = mult_new;
                            rep_d    = mult_new;
                            addend_d = (sel_grade == GR_PERFECT) ? PERFECT_BCD : GOOD_BCD;
                            d_d      = '0;
                            carry_d  = 1'b0;
                            work_d   = score_q;
                            state_d  = S_ADD;
                        end else begin
                            combo_d = '0;
                            mult_d  = 3'd1;
                        end
                    end
                end
                S_ADD: begin
                    work_d[4*d_q +: 4] = add_sum;
                    carry_d = add_cout;
                    if (d_q == LAST_DIGIT) begin
                        if (add_cout) begin
                            work_d  = ALL_NINES;
                            score_d = ALL_NINES;
                            ovf_d   = 1'b1;
                            rep_d   = '0;
                            state_d = S_IDLE;
                        end else if (rep_q > 3'd1) begin
                            rep_d   = rep_q - 3'd1;
                            d_d     = '0;
                            carry_d = 1'b0;
                        end else begin
                            score_d = work_d;
                            state_d = S_IDLE;
                        end
                    end else begin
                        d_d = d_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            for (int i = 0; i < LANES; i++) begin
                if (hit_valid[i]) begin
                    if (pend_q[i] && !consume[i]) begin
                        drop_d = 1'b1;
                    end else begin
                        pend_d[i]         = 1'b1;
                        grade_d[2*i +: 2] = hit_grade[2*i +: 2];
                    end
                end
            end
        end
    end

    // State registers; reset abandons any add in progress
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            grade_q  <= '0;
            combo_q  <= '0;
            mult_q   <= 3'd1;
            addend_q <= '0;
            rep_q    <= '0;
            d_q      <= '0;
            carry_q  <= 1'b0;
            work_q   <= '0;
            score_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            grade_q  <= grade_d;
            combo_q  <= combo_d;
            mult_q   <= mult_d;
            addend_q <= addend_d;
            rep_q    <= rep_d;
            d_q      <= d_d;
            carry_q  <= carry_d;
            work_q   <= work_d;
            score_q  <= score_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [W-1:0] hi_q, hi_d;
    logic         sat_commit;

    // Valid packed BCD orders the same as its binary reading, so a plain compare is MSD-first magnitude
    assign sat_commit = (state_q == S_ADD) && (d_q == LAST_DIGIT) && add_cout && !clear;

    // Capture a new high score on game restart or when the score saturates
    always_comb begin
        hi_d = hi_q;
        if (clear) begin
            if (score_q > hi_q) hi_d = score_q;
        end else if (sat_commit) begin
            if (ALL_NINES > hi_q) hi_d = ALL_NINES;
        end
    end

    // High score register, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) hi_q <= '0;
        else       hi_q <= hi_d;
    end

    assign hiscore_bcd = hi_q;
`else
    assign hiscore_bcd = '0;
`endif

    assign score_bcd = score_q;
    assign combo     = combo_q;
    assign mult      = mult_q;
    assign busy      = (state_q == S_ADD) || (|pend_q);
    assign overflow  = ovf_q;
    assign dropped   = drop_q;

endmodule
